// File: rtl/corrimiento_derecha_secuencial_pkg.sv
// Shared constants and state encoding for the sequential right shifter.
// Encodings match the ones the left-shift unit's benches already use.
package corrimiento_derecha_secuencial_pkg;

  localparam int WIDTH   = 32;
  localparam int SHAMT_W = 5;

  typedef enum logic [1:0] {
    REPOSO   = 2'd0,
    DESPLAZA = 2'd1,
    FIN      = 2'd2
  } estado_t;

endpackage

// File: rtl/corrimiento_derecha_secuencial_if.sv
// Request/result bundle between the datapath controller and the right shifter.
interface corrimiento_derecha_secuencial_if;
  import corrimiento_derecha_secuencial_pkg::*;

  logic               start;
  logic [WIDTH-1:0]   in_dato;
  logic [SHAMT_W-1:0] shamt;
  logic               aritmetico;
  logic               redondear;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   out;

  modport master (
    output start, in_dato, shamt, aritmetico, redondear,
    input  busy, done, out
  );

  modport slave (
    input  start, in_dato, shamt, aritmetico, redondear,
    output busy, done, out
  );

endinterface

// File: rtl/corrimiento_derecha_secuencial_paso.sv
// One-bit right-shift step: fills the top bit with the sign when arithmetic.
module paso_corrimiento
  import corrimiento_derecha_secuencial_pkg::*;
(
  input  logic [WIDTH-1:0] acc,
  input  logic             aritmetico,
  output logic [WIDTH-1:0] acc_next,
  output logic             bit_out
);

  assign acc_next = {aritmetico & acc[WIDTH-1], acc[WIDTH-1:1]};
  assign bit_out  = acc[0];

endmodule

// File: rtl/corrimiento_derecha_secuencial.sv
// Multi-cycle right shifter: divides by 2^shamt one bit per clock, optional
// sign extension and round-half-up using the last bit shifted out.
//
//   state    | meaning
//   REPOSO   | idle, waiting for start
//   DESPLAZA | shifting one bit per cycle, counter counts down to zero
//   FIN      | result latched into out on the leaving edge; start accepted here too
module corrimiento_derecha_secuencial
  import corrimiento_derecha_secuencial_pkg::*;
(
  input logic                         clk,
  input logic                         rst_n,
  corrimiento_derecha_secuencial_if.slave bus
);

  estado_t            estado, estado_next;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   acc_next;
  logic [SHAMT_W-1:0] cnt;
  logic               guard;
  logic               bit_out;
  logic               arit;
  logic               red;
  logic [WIDTH-1:0]   out_r;
  logic               done_r;
  logic               captura;
  logic               finaliza;

  paso_corrimiento u_paso (
    .acc        (acc),
    .aritmetico (arit),
    .acc_next   (acc_next),
    .bit_out    (bit_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) estado <= REPOSO;
    else        estado <= estado_next;
  end

  always_comb begin
    estado_next = estado;
    captura     = 1'b0;
    finaliza    = 1'b0;
    case (estado)
      REPOSO:   captura = bus.start;
      DESPLAZA: if (cnt == SHAMT_W'(1)) estado_next = FIN;
      FIN: begin
        finaliza    = 1'b1;
        estado_next = REPOSO;
        captura     = bus.start;
      end
      default:  estado_next = REPOSO;
    endcase
    if (captura) estado_next = (bus.shamt == '0) ? FIN : DESPLAZA;
  end

  // done and out are registered so both appear together the cycle after FIN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      cnt    <= '0;
      guard  <= 1'b0;
      arit   <= 1'b0;
      red    <= 1'b0;
      out_r  <= '0;
      done_r <= 1'b0;
    end else begin
      done_r <= finaliza;
      if (finaliza) out_r <= acc + WIDTH'(red & guard);
      if (captura) begin
        acc   <= bus.in_dato;
        cnt   <= bus.shamt;
        arit  <= bus.aritmetico;
        red   <= bus.redondear;
        guard <= 1'b0;
      end else if (estado == DESPLAZA) begin
        acc   <= acc_next;
        guard <= bit_out;
        cnt   <= cnt - SHAMT_W'(1);
      end
    end
  end

  assign bus.busy = (estado == DESPLAZA);
  assign bus.done = done_r;
  assign bus.out  = out_r;

endmodule

// File: tb/tb_corrimiento_derecha_secuencial.sv
// Directed bench for the sequential right shifter; expected values hand-computed.
module tb_corrimiento_derecha_secuencial;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  corrimiento_derecha_secuencial_if bus_if ();

  corrimiento_derecha_secuencial dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] d, input logic [4:0] s, input logic a, input logic r);
    bus_if.start      = 1'b1;
    bus_if.in_dato    = d;
    bus_if.shamt      = s;
    bus_if.aritmetico = a;
    bus_if.redondear  = r;
  endtask

  // drop start and scramble operands to show they are not re-read after acceptance
  task automatic release_start();
    bus_if.start      = 1'b0;
    bus_if.in_dato    = 32'hA5A5A5A5;
    bus_if.shamt      = 5'd7;
    bus_if.aritmetico = 1'b1;
    bus_if.redondear  = 1'b1;
  endtask

  task automatic run_op(input logic [31:0] d, input logic [4:0] s, input logic a, input logic r,
                        output logic [31:0] res, output int lat);
    @(negedge clk);
    drive(d, s, a, r);
    tick();
    release_start();
    lat = 0;
    while (!bus_if.done && lat < 100) begin
      tick();
      lat++;
    end
    res = bus_if.out;
  endtask

  task automatic vec(input string tag, input logic [31:0] d, input logic [4:0] s,
                     input logic a, input logic r, input logic [31:0] exp);
    logic [31:0] res;
    int lat;
    run_op(d, s, a, r, res, lat);
    check_val({tag, "_out"}, res, exp);
    check_val({tag, "_lat"}, 32'(lat), 32'(s) + 32'd1);
    tick();
    check_val({tag, "_pulse"}, {31'd0, bus_if.done}, 32'd0);
  endtask

  initial begin
    logic [31:0] res;
    int lat;
    total = 0;
    bad   = 0;

    // reset with start held high: nothing may move
    rst_n = 1'b0;
    drive(32'h12345678, 5'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("rst_busy", {31'd0, bus_if.busy}, 32'd0);
      check_val("rst_done", {31'd0, bus_if.done}, 32'd0);
      check_val("rst_out", bus_if.out, 32'h00000000);
    end
    @(negedge clk);
    bus_if.start = 1'b0;
    rst_n = 1'b1;
    tick();

    vec("log_shr2",   32'h00000100, 5'd2,  1'b0, 1'b0, 32'h00000040);
    vec("ari_rnd",    32'hFFFFFFF5, 5'd1,  1'b1, 1'b1, 32'hFFFFFFFB);
    vec("ari_trunc",  32'hFFFFFFF5, 5'd1,  1'b1, 1'b0, 32'hFFFFFFFA);
    vec("sh0",        32'h12345678, 5'd0,  1'b0, 1'b0, 32'h12345678);
    vec("sh0_rnd",    32'h12345679, 5'd0,  1'b1, 1'b1, 32'h12345679);
    vec("sh31_ari",   32'h80000000, 5'd31, 1'b1, 1'b0, 32'hFFFFFFFF);
    vec("sh31_log",   32'h80000000, 5'd31, 1'b0, 1'b0, 32'h00000001);
    vec("sh31_rnd",   32'hC0000000, 5'd31, 1'b1, 1'b1, 32'h00000000);
    vec("pos_rnd",    32'h00000007, 5'd1,  1'b0, 1'b1, 32'h00000004);
    vec("log_neg",    32'hFFFFFFF5, 5'd4,  1'b0, 1'b1, 32'h0FFFFFFF);
    vec("word_idx",   32'h00001000, 5'd2,  1'b0, 1'b0, 32'h00000400);
    vec("div8_rnd",   32'h0000005C, 5'd3,  1'b1, 1'b1, 32'h0000000C);

    // start while busy is ignored
    @(negedge clk);
    drive(32'h00012340, 5'd4, 1'b0, 1'b0);
    tick();
    release_start();
    tick();
    check_val("ign_busy", {31'd0, bus_if.busy}, 32'd1);
    drive(32'hDEADBEEF, 5'd0, 1'b0, 1'b0);
    tick();
    release_start();
    lat = 2;
    while (!bus_if.done && lat < 100) begin
      tick();
      lat++;
    end
    check_val("ign_out", bus_if.out, 32'h00001234);
    check_val("ign_lat", 32'(lat), 32'd5);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_val("ign_noq", {31'd0, bus_if.done}, 32'd0);
    end
    check_val("ign_hold", bus_if.out, 32'h00001234);

    // back-to-back: second op accepted in FIN
    @(negedge clk);
    drive(32'h00000100, 5'd2, 1'b0, 1'b0);
    tick();
    release_start();
    tick();
    tick();
    check_val("b2b_fin_busy", {31'd0, bus_if.busy}, 32'd0);
    drive(32'h00000006, 5'd1, 1'b0, 1'b0);
    tick();
    release_start();
    check_val("b2b_done1", {31'd0, bus_if.done}, 32'd1);
    check_val("b2b_out1", bus_if.out, 32'h00000040);
    check_val("b2b_busy2", {31'd0, bus_if.busy}, 32'd1);
    tick();
    check_val("b2b_gap", {31'd0, bus_if.done}, 32'd0);
    tick();
    check_val("b2b_done2", {31'd0, bus_if.done}, 32'd1);
    check_val("b2b_out2", bus_if.out, 32'h00000003);

    // reset in the middle of a long shift
    @(negedge clk);
    drive(32'h12345678, 5'd20, 1'b1, 1'b0);
    tick();
    release_start();
    for (int i = 0; i < 4; i++) tick();
    rst_n = 1'b0;
    #1;
    check_val("midrst_busy", {31'd0, bus_if.busy}, 32'd0);
    check_val("midrst_out", bus_if.out, 32'h00000000);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("midrst_done", {31'd0, bus_if.done}, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 25; i++) begin
      tick();
      check_val("post_rst_nodone", {31'd0, bus_if.done}, 32'd0);
    end
    run_op(32'h000000F0, 5'd4, 1'b0, 1'b0, res, lat);
    check_val("post_rst_out", res, 32'h0000000F);
    check_val("post_rst_lat", 32'(lat), 32'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
